// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Arbitrates a loader port and an instruction-fetch port onto one
//            single-port RAM, with loader lock and a bounded starvation window.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ld_req,
    input  logic              ld_wr,
    input  logic              ld_lock,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic              ram_rd,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int              CNT_W      = $clog2(MAX_LOCK + 1);
    localparam logic            c_OWNER_IF = 1'b0;
    localparam logic            c_OWNER_LD = 1'b1;
    localparam logic [CNT_W-1:0] c_LOCK_MAX = CNT_W'(MAX_LOCK);

    logic             r_last_owner;
    logic [CNT_W-1:0] r_lock_cnt;
    logic             r_ld_rvalid;
    logic             r_if_rvalid;
    logic             w_ld_gnt;
    logic             w_if_gnt;

    // Grants are gated by reset_n so nothing reaches the RAM while reset is held.
    always_comb begin
        w_ld_gnt = 1'b0;
        w_if_gnt = 1'b0;
        if (reset_n) begin
            if (ld_req && !if_req) begin
                w_ld_gnt = 1'b1;
            end else if (if_req && !ld_req) begin
                w_if_gnt = 1'b1;
            end else if (ld_req && if_req) begin
                if (r_lock_cnt == c_LOCK_MAX) begin
                    w_if_gnt = 1'b1;
                end else if (ld_lock && (r_last_owner == c_OWNER_LD)) begin
                    w_ld_gnt = 1'b1;
                end else if (r_last_owner == c_OWNER_LD) begin
                    w_if_gnt = 1'b1;
                end else begin
                    w_ld_gnt = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wr    = 1'b0;
        ram_rd    = 1'b0;
        if (w_ld_gnt) begin
            ram_addr  = ld_addr;
            ram_wdata = ld_wdata;
            ram_wr    = ld_wr;
            ram_rd    = ~ld_wr;
        end else if (w_if_gnt) begin
            ram_addr  = if_addr;
            ram_rd    = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_owner <= c_OWNER_IF;
            r_lock_cnt   <= '0;
            r_ld_rvalid  <= 1'b0;
            r_if_rvalid  <= 1'b0;
        end else begin
            r_ld_rvalid <= w_ld_gnt & ~ld_wr;
            r_if_rvalid <= w_if_gnt;

            if (w_ld_gnt) begin
                r_last_owner <= c_OWNER_LD;
            end else if (w_if_gnt) begin
                r_last_owner <= c_OWNER_IF;
            end

            // Only contended locked loader grants count toward the yield bound.
            if (w_if_gnt || !ld_lock || !ld_req) begin
                r_lock_cnt <= '0;
            end else if (w_ld_gnt && if_req && (r_lock_cnt != c_LOCK_MAX)) begin
                r_lock_cnt <= r_lock_cnt + CNT_W'(1);
            end
        end
    end

    assign ld_gnt    = w_ld_gnt;
    assign if_gnt    = w_if_gnt;
    assign ld_rvalid = r_ld_rvalid;
    assign if_rvalid = r_if_rvalid;
    assign rdata     = ram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed scoreboard bench for mem_arbiter with a behavioural RAM.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int ML = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          ld_req = 1'b0, ld_wr = 1'b0, ld_lock = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_wdata = '0;
    logic          ld_gnt, ld_rvalid;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_wr, ram_rd;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic          who_ld;
        logic [DW-1:0] data;
        int            due;
    } rd_t;
    rd_t q[$];

    logic [DW-1:0] mem [0:(1<<AW)-1];

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
        .clock(clock), .reset_n(reset_n),
        .ld_req(ld_req), .ld_wr(ld_wr), .ld_lock(ld_lock),
        .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
        .if_req(if_req), .if_addr(if_addr),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .rdata(rdata),
        .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_rd(ram_rd),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (ram_wr) mem[ram_addr] <= ram_wdata;
        if (ram_rd) ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Read-return monitor: every rvalid must match the oldest outstanding read.
    always @(negedge clock) begin
        if (ld_rvalid || if_rvalid) begin
            rd_t e;
            n_checks++;
            if (ld_rvalid && if_rvalid) begin
                n_fail++;
                $display("FAIL rvalid_both: got ld=1 if=1 required at most one");
            end else if (q.size() == 0) begin
                n_fail++;
                $display("FAIL rvalid_unexpected: got ld=%0d if=%0d required none", ld_rvalid, if_rvalid);
            end else begin
                e = q.pop_front();
                if (e.who_ld !== ld_rvalid || e.data !== rdata || e.due != cyc) begin
                    n_fail++;
                    $display("FAIL rvalid_data: got ld=%0d data=%h cyc=%0d required ld=%0d data=%h cyc=%0d",
                             ld_rvalid, rdata, cyc, e.who_ld, e.data, e.due);
                end
            end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL rvalid_missing: got none required ld=%0d data=%h", q[0].who_ld, q[0].data);
            void'(q.pop_front());
        end
    end

    task automatic drive(input logic lr, input logic lw, input logic ll, input logic [AW-1:0] la,
                         input logic [DW-1:0] lwd, input logic ir, input logic [AW-1:0] ia);
        @(posedge clock);
        #1;
        ld_req = lr; ld_wr = lw; ld_lock = ll; ld_addr = la; ld_wdata = lwd;
        if_req = ir; if_addr = ia;
        @(negedge clock);
    endtask

    task automatic check_gnt(input string nm, input logic el, input logic ei);
        logic          ew, er;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd;
        ew  = el & ld_wr;
        er  = (el & ~ld_wr) | ei;
        ea  = el ? ld_addr : (ei ? if_addr : '0);
        ewd = el ? ld_wdata : '0;
        check({nm, "_gnt"},    64'({ld_gnt, if_gnt}), 64'({el, ei}));
        check({nm, "_strobe"}, 64'({ram_wr, ram_rd}), 64'({ew, er}));
        check({nm, "_addr"},   64'(ram_addr),  64'(ea));
        check({nm, "_wdata"},  64'(ram_wdata), 64'(ewd));
    endtask

    task automatic expect_gnt(input string nm, input logic el, input logic ei, input logic [DW-1:0] erd);
        check_gnt(nm, el, ei);
        if ((el && !ld_wr) || ei) q.push_back('{who_ld: el, data: erd, due: cyc + 1});
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        ld_req  = 1'b1;
        if_req  = 1'b1;
        @(negedge clock);
        check_gnt("rst_hold", 1'b0, 1'b0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        ld_req  = 1'b0;
        if_req  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        ld_req = 1'b1;
        if_req = 1'b1;
        repeat (2) @(negedge clock);
        check_gnt("reset", 1'b0, 1'b0);
        check("reset_rvalid", 64'({ld_rvalid, if_rvalid}), 64'(0));
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        ld_req  = 1'b0;
        if_req  = 1'b0;

        // Loader writes, then fetch reads back the same words.
        drive(1'b1, 1'b1, 1'b0, 9'd0, 32'h10F00010, 1'b0, '0);
        expect_gnt("ld_wr0", 1'b1, 1'b0, '0);
        drive(1'b1, 1'b1, 1'b0, 9'd1, 32'h20010000, 1'b0, '0);
        expect_gnt("ld_wr1", 1'b1, 1'b0, '0);
        drive(1'b1, 1'b1, 1'b0, 9'd3, 32'h0000ABCD, 1'b0, '0);
        expect_gnt("ld_wr3", 1'b1, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 9'd0);
        expect_gnt("if_rd0", 1'b0, 1'b1, 32'h10F00010);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 9'd1);
        expect_gnt("if_rd1", 1'b0, 1'b1, 32'h20010000);
        drive(1'b1, 1'b0, 1'b0, 9'd3, '0, 1'b0, '0);
        expect_gnt("ld_rd3", 1'b1, 1'b0, 32'h0000ABCD);

        // Unlocked contention alternates, loader first after reset.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 9'd1, '0, 1'b1, 9'd0);
            if (i % 2 == 0) expect_gnt("rr_ld", 1'b1, 1'b0, 32'h20010000);
            else            expect_gnt("rr_if", 1'b0, 1'b1, 32'h10F00010);
        end

        // Locked contention: 16 loader grants, one forced fetch, loader resumes.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, 1'b1, 1'b1, 9'd10, 32'h55AA0000 + DW'(i), 1'b1, 9'd0);
            if (i == ML) expect_gnt("lock_if", 1'b0, 1'b1, 32'h10F00010);
            else         expect_gnt("lock_ld", 1'b1, 1'b0, '0);
        end
        drive(1'b1, 1'b0, 1'b0, 9'd3, '0, 1'b1, 9'd1);
        expect_gnt("unlock_if", 1'b0, 1'b1, 32'h20010000);

        // Reset lands after a loader read grant, before its rvalid registers.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 9'd3, '0, 1'b0, '0);
        check_gnt("rst_rd3", 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_gnt", 64'({ld_gnt, if_gnt, ram_rd, ram_wr}), 64'(0));
        @(posedge clock);
        #1;
        check("rst_mid_rvalid", 64'({ld_rvalid, if_rvalid}), 64'(0));
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        ld_req  = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_post_rvalid", 64'({ld_rvalid, if_rvalid}), 64'(0));

        // Loader withdraws a pending write while fetch holds the turn.
        drive(1'b1, 1'b0, 1'b0, 9'd2, '0, 1'b0, '0);
        expect_gnt("wd_ld_rd2", 1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 9'd4, 32'hDEADBEEF, 1'b1, 9'd1);
        expect_gnt("wd_if_turn", 1'b0, 1'b1, 32'h20010000);
        drive(1'b0, 1'b1, 1'b0, 9'd4, 32'hDEADBEEF, 1'b0, '0);
        expect_gnt("wd_idle", 1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 9'd4);
        expect_gnt("wd_readback", 1'b0, 1'b1, 32'h0);

        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        repeat (3) @(negedge clock);
        check("sb_drain", 64'(q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
